// File: rtl/core_pkg.sv
// core_pkg: shared constants for the RV32I core pipeline stages
package core_pkg;
  localparam int XLEN_DEF = 32;
  localparam int CTRL_W = 11;
  localparam int CTRL_REGWRITE = 10;
  localparam int CTRL_MEMREAD = 9;
  localparam int CTRL_MEMWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_BRANCH = 6;
  localparam int CTRL_ALUSRC = 5;
  localparam int CTRL_ALUOP = 3;
  localparam int CTRL_FUNCT3 = 0;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load sitting in EX
module load_use_detect
  import core_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       flush_i,
  output logic       lu_o,
  output logic       stall_o
);
  always_comb begin
    lu_o = ex_valid_i & ex_memread_i & (ex_rd_i != REG_ZERO) & id_valid_i &
           ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) | (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
    stall_o = lu_o & ~flush_i;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and bubble counter
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              id_funct7b5_i,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              ex_funct7b5_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  logic              valid_q, valid_d, f7_q, f7_d, lu, kill, load;
  logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d, id_ctrl;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  load_use_detect u_lud (
    .ex_valid_i    (valid_q),
    .ex_memread_i  (ctrl_q[CTRL_MEMREAD]),
    .ex_rd_i       (rd_q),
    .id_valid_i    (id_valid_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .flush_i       (flush_i),
    .lu_o          (lu),
    .stall_o       (stall_o)
  );

  // flush beats hold, hold beats load-use; an invalid slot can never write back
  always_comb begin
    kill = flush_i | (~hold_i & lu);
    load = ~flush_i & ~hold_i & ~lu;
    id_ctrl = id_ctrl_i;
    id_ctrl[CTRL_REGWRITE] = id_ctrl_i[CTRL_REGWRITE] & id_valid_i;
    valid_d    = kill ? 1'b0 : load ? id_valid_i    : valid_q;
    pc_d       = kill ? '0   : load ? id_pc_i       : pc_q;
    rs1_data_d = kill ? '0   : load ? id_rs1_data_i : rs1_data_q;
    rs2_data_d = kill ? '0   : load ? id_rs2_data_i : rs2_data_q;
    imm_d      = kill ? '0   : load ? id_imm_i      : imm_q;
    rs1_d      = kill ? '0   : load ? id_rs1_i      : rs1_q;
    rs2_d      = kill ? '0   : load ? id_rs2_i      : rs2_q;
    rd_d       = kill ? '0   : load ? id_rd_i       : rd_q;
    ctrl_d     = kill ? '0   : load ? id_ctrl       : ctrl_q;
    f7_d       = kill ? 1'b0 : load ? id_funct7b5_i : f7_q;
    cnt_d      = (~flush_i & ~hold_i & lu & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      f7_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      f7_q       <= f7_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    ex_valid_o    = valid_q;
    ex_pc_o       = pc_q;
    ex_rs1_data_o = rs1_data_q;
    ex_rs2_data_o = rs2_data_q;
    ex_imm_o      = imm_q;
    ex_rs1_o      = rs1_q;
    ex_rs2_o      = rs2_q;
    ex_rd_o       = rd_q;
    ex_ctrl_o     = ctrl_q;
    ex_funct7b5_o = f7_q;
    bubble_cnt_o  = cnt_q;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core. It also contains the load-use hazard detector.
- Captures decoded operands and control from the ID stage. Drives the `ex_*` fields consumed by the EX stage and the operand forwarding logic (`ex_rs1`, `ex_rs2` feed forward-select comparison).
- Inserts a bubble on load-use, kills the instruction on branch flush, and holds on back-pressure.
- Counts inserted bubbles for performance monitoring.

Parameters:
- XLEN, 32, datapath width for pc, operands and immediate
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- hold_i  in  1  back-pressure from MEM (data memory busy); freeze register contents
- flush_i  in  1  branch/jump taken in EX; kill the instruction entering ID/EX
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  ID pc
- id_rs1_data_i / id_rs2_data_i  in  XLEN  register file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_i / id_rs2_i / id_rd_i  in  5  register indices
- id_uses_rs1_i / id_uses_rs2_i  in  1  instruction actually reads rs1/rs2
- id_ctrl_i  in  11  {regwrite, memread, memwrite, memtoreg, branch, alusrc, aluop[1:0], funct3[2:0]}; funct7b5 is passed separately
- id_funct7b5_i  in  1  instr[30]
- ex_valid_o  out  1
- ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5
- ex_ctrl_o  out  11;  ex_funct7b5_o  out  1
- stall_o  out  1  load-use stall; IF/ID and PC must not advance
- bubble_cnt_o  out  CNT_W  number of bubbles inserted, saturating

Behaviour:
- Reset (async on rst_n low, released synchronously by design convention): all outputs and registers go to 0. `ex_valid_o` = 0 and `bubble_cnt_o` = 0.
- Load-use detect (combinational from registered state plus ID inputs):
  - `lu` = ex_valid_o & ex_ctrl_o.memread & (ex_rd_o != 0) & id_valid_i & ((id_uses_rs1_i & id_rs1_i == ex_rd_o) | (id_uses_rs2_i & id_rs2_i == ex_rd_o)).
  - `stall_o` = lu & ~flush_i. Its value is independent of hold_i.
- Register update each posedge, first matching rule wins:
  1. flush_i = 1: load bubble. Wins even when hold_i = 1, because a branch redirect invalidates the slot.
  2. hold_i = 1: all fields keep their value, counter unchanged.
  3. lu = 1: load bubble; bubble_cnt += 1 unless it is at all-ones.
  4. Otherwise capture all `id_*` inputs; ex_valid_o <= id_valid_i.
- Bubble definition: ex_valid_o = 0; ex_ctrl_o, ex_funct7b5_o, ex_rd_o, ex_rs1_o and ex_rs2_o = 0; data fields (pc, operands, imm) = 0.
  - Zero rd and regwrite guarantee that no downstream forwarding match or writeback occurs.
- Flush bubbles are not counted. Only load-use bubbles increment the counter.
- Counter saturation: at 2^CNT_W-1 it stays there.
- Latency: one cycle from ID inputs to `ex_*`. The load-use stall lasts exactly one cycle: after the bubble, ex_ctrl_o.memread = 0, so lu deasserts.
- Invalid ID input (id_valid_i = 0) never produces lu. It is captured as invalid, and control is still captured verbatim. Downstream must qualify with valid; regwrite is therefore forced to 0 when id_valid_i = 0.
- Reset mid-stall: all state is cleared immediately and stall_o drops in the same cycle (ex_valid_o = 0).

Decomposition:
- Shared package `core_pkg`:
  - control bit index constants (CTRL_REGWRITE .. CTRL_FUNCT3) and CTRL_W = 11
  - XLEN default
  - zero-register constant
- One natural sub-module: `load_use_detect` (pure combinational lu/stall equation). The register and counter stay in the top.

Test Plan:
- Reset: rst_n low mid-operation with ex_valid_o = 1 -> all outputs 0 asynchronously; bubble_cnt_o = 0.
- Load-use on rs1: EX holds lw x5 (memread = 1, rd = 5); ID presents add x6,x5,x7 (uses_rs1) -> stall_o = 1 that cycle. Next cycle ex_valid_o = 0, ex_rd_o = 0, bubble_cnt_o = 1. The cycle after, the add is captured and stall_o = 0.
- No false stall: lw x0 followed by use of x0 -> stall_o = 0. Also lw x5 followed by lui x5 (uses_rs1 = uses_rs2 = 0) -> stall_o = 0.
- Flush precedence: lu = 1 and flush_i = 1 in the same cycle -> stall_o = 0; bubble loaded; bubble_cnt_o unchanged.
- Hold: hold_i = 1 for 3 cycles with a changing ID input -> ex_* stays stable. Then flush_i together with hold_i -> bubble loaded.
- Saturation with CNT_W = 2: force 5 load-use bubbles -> bubble_cnt_o goes 1, 2, 3, 3, 3.
